// File: rtl/freq_counter_pkg.sv
// Shared types and helpers for the frequency-counter blocks.
package freq_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        GATE  = 2'd2,
        LATCH = 2'd3
    } state_e;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pulse_edge_sync.sv
// Synchronizes an asynchronous pulse stream and flags its rising edges.
module pulse_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pulse,
    input  logic i_load_hist,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pulse};
            r_hist <= w_level;
        end
    end

    // While the history is being loaded, any level seen is treated as old.
    assign o_edge = w_level & ~r_hist & ~i_load_hist;

endmodule

// File: rtl/freq_gate_controller.sv
// Measurement sequencer: clears the divider, counts divided edges over a fixed gate, latches the result.
module freq_gate_controller
    import freq_counter_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int COUNT_W     = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CLR_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               continuous,
    input  logic               pulse_in,
    output logic               div_rst,
    output logic               busy,
    output logic [COUNT_W-1:0] count,
    output logic               count_valid,
    output logic               overflow
);

    localparam int            GW        = cnt_width(GATE_CYCLES);
    localparam int            CW        = cnt_width(CLR_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);

    state_e             r_state, w_next;
    logic [GW-1:0]      r_gate_cnt;
    logic [CW-1:0]      r_clr_cnt;
    logic [COUNT_W-1:0] r_ecnt, w_ecnt_nxt;
    logic               r_sat, w_sat_nxt;
    logic               w_edge;

    pulse_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_pulse    (pulse_in),
        .i_load_hist(r_state == CLEAR),
        .o_edge     (w_edge)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CLEAR;
            CLEAR:   if (r_clr_cnt == CLR_LAST) w_next = GATE;
            GATE:    if (r_gate_cnt == GATE_LAST) w_next = LATCH;
            LATCH:   w_next = continuous ? CLEAR : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Saturating edge counter; the next value feeds the latch so a final-cycle edge is kept.
    always_comb begin
        w_ecnt_nxt = r_ecnt;
        w_sat_nxt  = r_sat;
        if (r_state == CLEAR) begin
            w_ecnt_nxt = '0;
            w_sat_nxt  = 1'b0;
        end else if (r_state == GATE && w_edge) begin
            if (&r_ecnt) w_sat_nxt  = 1'b1;
            else         w_ecnt_nxt = r_ecnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gate_cnt  <= '0;
            r_clr_cnt   <= '0;
            r_ecnt      <= '0;
            r_sat       <= 1'b0;
            div_rst     <= 1'b0;
            count       <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ecnt      <= w_ecnt_nxt;
            r_sat       <= w_sat_nxt;
            r_clr_cnt   <= (r_state == CLEAR && w_next == CLEAR) ? r_clr_cnt + 1'b1 : '0;
            r_gate_cnt  <= (r_state == GATE && w_next == GATE) ? r_gate_cnt + 1'b1 : '0;
            div_rst     <= (w_next == CLEAR);
            count_valid <= (w_next == LATCH);
            if (r_state == GATE && w_next == LATCH) begin
                count    <= w_ecnt_nxt;
                overflow <= w_sat_nxt;
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_freq_gate_controller.sv
// Directed bench for freq_gate_controller: a 32-bit and a 4-bit instance share one stimulus.
module tb_freq_gate_controller;

    localparam int GATE = 100;
    localparam int CLR  = 2;

    logic        clk = 1'b0;
    logic        rst, start, continuous, pulse_in;
    logic        div_rst, busy, count_valid, overflow;
    logic [31:0] count;
    logic        div_rst4, busy4, count_valid4, overflow4;
    logic [3:0]  count4;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int period = 0;
    logic level = 1'b0;

    freq_gate_controller #(.GATE_CYCLES(GATE), .COUNT_W(32), .SYNC_STAGES(2), .CLR_CYCLES(CLR)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .pulse_in(pulse_in),
        .div_rst(div_rst), .busy(busy), .count(count), .count_valid(count_valid), .overflow(overflow)
    );

    freq_gate_controller #(.GATE_CYCLES(GATE), .COUNT_W(4), .SYNC_STAGES(2), .CLR_CYCLES(CLR)) dut4 (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .pulse_in(pulse_in),
        .div_rst(div_rst4), .busy(busy4), .count(count4), .count_valid(count_valid4), .overflow(overflow4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse source changes a little after the clock edge, like an unrelated clock domain.
    initial begin
        int ph;
        ph = 0;
        pulse_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (period == 0) pulse_in = level;
            else begin
                ph = (ph + 1 >= period) ? 0 : ph + 1;
                pulse_in = (ph < period / 2);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int limit, input string tag);
        int k;
        k = 0;
        while (count_valid !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "/valid_seen"}, count_valid, 1);
    endtask

    // One single-shot run; sample i is the cycle after start edge T plus i-1 further edges.
    task automatic run_single(input int p, input bit mid_start, input logic [31:0] ec,
                              input logic [31:0] eo, input logic [31:0] ec4,
                              input logic [31:0] eo4, input string tag);
        period = p;
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 104; i++) begin
            if (i > 1) @(negedge clk);
            start = (mid_start && i == 50);
            if (i == 1) begin
                chk({tag, "/busy_T1"}, busy, 1);
                chk({tag, "/divrst_T1"}, div_rst, 1);
            end
            if (i == 2) chk({tag, "/divrst_T2"}, div_rst, 1);
            if (i == 3) chk({tag, "/divrst_T3"}, div_rst, 0);
            if (i == 102) chk({tag, "/valid_T102"}, count_valid, 0);
            if (i == 103) begin
                chk({tag, "/valid_T103"}, count_valid, 1);
                chk({tag, "/count"}, count, ec);
                chk({tag, "/ovf"}, overflow, eo);
                chk({tag, "/count4"}, count4, ec4);
                chk({tag, "/ovf4"}, overflow4, eo4);
            end
            if (i == 104) begin
                chk({tag, "/busy_T104"}, busy, 0);
                chk({tag, "/valid_T104"}, count_valid, 0);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1, t2, t3, nv;
        rst = 1'b1; start = 1'b0; continuous = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst/busy", busy, 0);
        chk("rst/div_rst", div_rst, 0);
        chk("rst/count", count, 0);
        chk("rst/valid", count_valid, 0);
        chk("rst/ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        run_single(10, 1'b0, 10, 0, 10, 0, "single10");
        run_single(10, 1'b1, 10, 0, 10, 0, "start_in_gate");
        run_single(4,  1'b0, 25, 0, 15, 1, "sat4");
        run_single(20, 1'b0, 5,  0, 5,  0, "period20");
        level = 1'b1;
        run_single(0,  1'b0, 0,  0, 0,  0, "stuck_high");
        level = 1'b0;

        // Continuous back-to-back measurements, then a mid-gate stop request.
        continuous = 1'b1;
        period = 5;
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(200, "cont1");
        t1 = cyc;
        chk("cont1/count", count, 20);
        @(negedge clk);
        wait_valid(200, "cont2");
        t2 = cyc;
        chk("cont2/period", t2 - t1, 103);
        chk("cont2/count", count, 20);
        chk("cont2/count4", count4, 15);
        chk("cont2/ovf4", overflow4, 1);
        repeat (50) @(negedge clk);
        continuous = 1'b0;
        wait_valid(200, "cont3");
        t3 = cyc;
        chk("cont3/period", t3 - t2, 103);
        chk("cont3/count", count, 20);
        @(negedge clk);
        chk("cont_stop/busy", busy, 0);
        nv = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (count_valid === 1'b1) nv++;
        end
        chk("cont_stop/extra_valids", nv, 0);

        // Reset 50 cycles into the gate window aborts the run.
        period = 10;
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (52) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort/busy", busy, 0);
        chk("abort/div_rst", div_rst, 0);
        chk("abort/count", count, 0);
        chk("abort/count4", count4, 0);
        chk("abort/valid", count_valid, 0);
        nv = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (count_valid === 1'b1 || busy === 1'b1) nv++;
        end
        chk("abort/no_activity", nv, 0);
        run_single(10, 1'b0, 10, 0, 10, 0, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_gate_controller.md
Name: freq_gate_controller

Overview:
Measurement sequencer for the frequency counter. It resets the upstream pulse_divider, then opens a gate window of a fixed number of clk cycles. During the window it counts rising edges of the divided pulse stream, then latches the result with a one-cycle valid strobe. It supports single-shot and continuous (back-to-back) measurement.

Parameters:
GATE_CYCLES, 50_000_000, gate window length in clk cycles (1 s at 50 MHz); must be >= 2
COUNT_W, 32, width of edge counter and result
SYNC_STAGES, 2, synchronizer flops on pulse_in; must be >= 2
CLR_CYCLES, 2, cycles div_rst is held high before the gate opens; must be >= 1

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a measurement; sampled only in IDLE
continuous  in  1  when high, restart automatically after each result
pulse_in  in  1  divided pulse stream from pulse_divider; asynchronous to clk
div_rst  out  1  reset to pulse_divider; registered
busy  out  1  high whenever state != IDLE
count  out  COUNT_W  last latched edge count
count_valid  out  1  one-cycle strobe; count updated this cycle
overflow  out  1  last measurement saturated; updated together with count

Behaviour:
- Reset: state IDLE. div_rst=0, busy=0, count=0, count_valid=0, overflow=0. Edge counter, gate counter and synchronizer flops are all cleared.
- Input path: pulse_in passes through SYNC_STAGES flops, then one history flop. edge = sync_out & ~hist.
- States:
  - IDLE: stays here while start=0. When start=1, go to CLEAR.
  - CLEAR: div_rst=1 for exactly CLR_CYCLES cycles. Edge counter cleared; hist loaded with sync_out, so no spurious edge appears at gate open. Then go to GATE.
  - GATE: runs exactly GATE_CYCLES cycles; gate counter counts 0..GATE_CYCLES-1. Each cycle with edge=1 increments the edge counter. An edge on the final gate cycle is counted. Then go to LATCH.
  - LATCH: one cycle. count <= edge counter, overflow <= saturation flag, count_valid=1. Next state is CLEAR if continuous=1, else IDLE.
- Latency: start sampled at edge T. busy high from T+1. CLEAR occupies T+1..T+CLR_CYCLES. GATE occupies the next GATE_CYCLES cycles. count_valid is high in the following cycle (LATCH).
- Continuous period: CLR_CYCLES+GATE_CYCLES+1 cycles per result.
- count_valid is high only during LATCH and is 0 in every other cycle.
- Saturation: the edge counter stops at 2^COUNT_W-1. An edge arriving at saturation sets the saturation flag; it never wraps. The flag is cleared in CLEAR.
- start while busy: ignored, not queued.
- continuous deasserted mid-measurement: the current measurement completes, then the block returns to IDLE.
- continuous high in IDLE with start=0: no effect.
- count and overflow hold their last values until the next LATCH. They are not cleared by CLEAR.
- rst at any time, including mid-GATE: all reset values apply on the next edge. No count_valid is produced for the aborted run.
- pulse_in stuck high or low: count=0, overflow=0.
- Gate counter width is clog2(GATE_CYCLES). There is no wrap beyond GATE_CYCLES-1.

Decomposition:
- Shared package freq_counter_pkg holds the state enum (IDLE, CLEAR, GATE, LATCH) and a clog2-based width helper.
- One sub-module, pulse_edge_sync: SYNC_STAGES synchronizer plus history flop, with a load_hist input. It is reusable by other frequency-counter blocks.
- Gate counter and edge counter stay inline.

Test Plan:
- Single shot (GATE_CYCLES=100, CLR_CYCLES=2): pulse_in period 10 clk, pulse start at arbitrary phase, start pulsed once -> div_rst high 2 cycles, count_valid at cycle T+103, count=10, overflow=0, busy low at T+104.
- Saturation (COUNT_W=4, GATE_CYCLES=100): pulse period 4 clk -> count=15, overflow=1. Next run at period 20 -> count=5, overflow=0.
- Continuous: continuous=1, pulse period 5 clk, GATE_CYCLES=100 -> count_valid every 103 cycles, each count=20. Deassert continuous mid-gate -> exactly one more result, then busy=0.
- start asserted in GATE: no restart, single count_valid, timing unchanged from the single-shot case.
- rst asserted 50 cycles into GATE -> next cycle busy=0, div_rst=0, count=0, count_valid stays 0. A later start yields a normal result.
- pulse_in held at 1 through the whole run -> count=0 (no false edge at gate open), overflow=0.
